// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one operand bit pair per cycle to an external
// 1-bit full adder, collects the sum LSB-first and publishes it with a done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sumSh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_inAdd;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_sumNext;

    assign w_inAdd   = (r_state == ADD);
    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));
    // Sum bits arrive LSB-first, so each new bit enters at the top and slides down.
    assign w_sumNext = {fa_s, r_sumSh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sumSh <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= fa_cout;
                    r_sumSh <= w_sumNext;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_lastBit) begin
                        r_sum   <= w_sumNext;
                        r_cout  <= fa_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fa_a   = w_inAdd & r_a[0];
    assign fa_b   = w_inAdd & r_b[0];
    assign fa_cin = w_inAdd & r_carry;
    assign busy   = r_busy;
    assign done   = r_done;
    assign sum    = r_sum;
    assign cout   = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl with a behavioural full adder attached; results are
// predicted from plain integer addition of the operands captured at each accepted start.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;
    localparam int NUM_RANDOM_OPS = 1000;
    localparam int PERIOD = WIDTH + 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int               assertCount;
    int               failCount;
    logic [WIDTH-1:0] lastSum;
    logic             lastCout;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_s    (fa_s),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    // External 1-bit full adder stage.
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full operation with optional ignored start pulses during ADD bit injectBit and during DONE.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input int injectBit, input bit injectDone);
        logic [63:0] full;
        logic [63:0] mask;
        logic [63:0] carryIn;
        full = 64'(a) + 64'(b) + 64'(c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = WIDTH'($urandom);
        b_in  = WIDTH'($urandom);
        cin   = 1'($urandom);
        for (int k = 0; k < WIDTH; k++) begin
            mask    = (64'd1 << k) - 64'd1;
            carryIn = ((64'(a) & mask) + (64'(b) & mask) + 64'(c)) >> k;
            checkOutput("fa_bits", {61'd0, fa_a, fa_b, fa_cin},
                        {61'd0, a[k], b[k], carryIn[0]});
            checkOutput("busy_done_add", {62'd0, busy, done}, 64'd2);
            checkOutput("sum_hold", {55'd0, lastCout, lastSum}, {55'd0, cout, sum});
            if (k == injectBit) begin
                @(negedge clk);
                start = 1'b1;
                a_in  = 8'h11;
                b_in  = 8'h22;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("done_pulse", {62'd0, busy, done}, 64'd3);
        checkOutput("result", {55'd0, cout, sum}, {55'd0, full[WIDTH], full[WIDTH-1:0]});
        checkOutput("fa_idle_done", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
        lastSum  = full[WIDTH-1:0];
        lastCout = full[WIDTH];
        if (injectDone) begin
            @(negedge clk);
            start = 1'b1;
            a_in  = 8'h11;
            b_in  = 8'h22;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("back_to_idle", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("stays_idle", {55'd0, busy, done, sum}, {55'd0, 1'b0, 1'b0, lastSum});
    endtask

    task automatic resetMidOp();
        int doneSeen;
        doneSeen = 0;
        @(negedge clk);
        a_in  = 8'h3C;
        b_in  = 8'hA5;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outs", {52'd0, busy, done, cout, fa_a, fa_b, fa_cin, sum},
                    64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("no_done_after_abort", 64'(doneSeen), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        lastSum  = '0;
        lastCout = 1'b0;
        applyStimulus(8'h01, 8'h01, 1'b0, -1, 1'b0);
    endtask

    // Start held high with fresh random operands every cycle; accepts land every PERIOD edges.
    task automatic randomBackToBack();
        logic [WIDTH-1:0] capA;
        logic [WIDTH-1:0] capB;
        logic             capC;
        logic [63:0]      full;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
        capA    = '0;
        capB    = '0;
        capC    = 1'b0;
        expSum  = lastSum;
        expCout = lastCout;
        for (int cyc = 0; cyc < NUM_RANDOM_OPS * PERIOD; cyc++) begin
            @(negedge clk);
            start = 1'b1;
            a_in  = WIDTH'($urandom);
            b_in  = WIDTH'($urandom);
            cin   = 1'($urandom_range(0, 1));
            if (cyc % PERIOD == 0) begin
                capA = a_in;
                capB = b_in;
                capC = cin;
            end
            @(posedge clk);
            #1;
            if (cyc % PERIOD == WIDTH) begin
                full    = 64'(capA) + 64'(capB) + 64'(capC);
                expSum  = full[WIDTH-1:0];
                expCout = full[WIDTH];
            end
            checkOutput("rand_cycle", {53'd0, busy, done, cout, sum},
                        {53'd0, (cyc % PERIOD != PERIOD - 1), (cyc % PERIOD == WIDTH),
                         expCout, expSum});
        end
        @(negedge clk);
        start    = 1'b0;
        lastSum  = expSum;
        lastCout = expCout;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        lastSum     = '0;
        lastCout    = 1'b0;
        start       = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin         = 1'b0;
        reset       = 1'b1;
        #12;
        checkOutput("reset_state", {52'd0, busy, done, cout, fa_a, fa_b, fa_cin, sum}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_after_reset", {62'd0, busy, done}, 64'd0);

        $display("[TB] directed operations");
        applyStimulus(8'h00, 8'h00, 1'b0, -1, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, -1, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, -1, 1'b0);
        applyStimulus(8'h3C, 8'hA5, 1'b0, -1, 1'b0);

        $display("[TB] start pulses while busy");
        applyStimulus(8'hFF, 8'h01, 1'b0, -1, 1'b0);
        applyStimulus(8'h3C, 8'hA5, 1'b0, 3, 1'b1);

        $display("[TB] reset during ADD");
        resetMidOp();

        $display("[TB] random back-to-back operations");
        randomBackToBack();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
